// File: rtl/controller_sequencer_if.sv
// SAP-1 sequencer bundle: opcode/flag in, ring state and control word out.
interface controller_sequencer_if;
   logic [3:0] opcode;
   logic       zero_flag;
   logic [5:0] t_state;
   logic       halt;
   logic       cp;
   logic       ep;
   logic       low_lp;
   logic       low_lm;
   logic       low_ce;
   logic       low_li;
   logic       low_ei;
   logic       low_la;
   logic       ea;
   logic       su;
   logic       eu;
   logic       low_lb;
   logic       low_lo;

   modport master (
      input  opcode, zero_flag,
      output t_state, halt,
      output cp, ep, low_lp, low_lm,
      output low_ce, low_li, low_ei,
      output low_la, ea, su, eu,
      output low_lb, low_lo
   );

   modport slave (
      output opcode, zero_flag,
      input  t_state, halt,
      input  cp, ep, low_lp, low_lm,
      input  low_ce, low_li, low_ei,
      input  low_la, ea, su, eu,
      input  low_lb, low_lo
   );
endinterface

// File: rtl/controller_sequencer.sv
// SAP-1 T1..T6 ring-counter control sequencer.
// Optional jumps (JMP/JZ) with `define CONTROLLER_JUMP_EN.
module controller_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'h3,
   parameter logic [3:0] OP_HLT = 4'hF,
   parameter logic [3:0] OP_JMP = 4'h4,
   parameter logic [3:0] OP_JZ  = 4'h5
) (
   input logic clk,
   input logic sync_reset,
   controller_sequencer_if.master bus
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_e;

   t_e   state, state_n;
   logic halt_q, halt_n;

   logic is_lda, is_add, is_sub;
   logic is_out, is_hlt, take_jmp;

   assign is_lda = bus.opcode == OP_LDA;
   assign is_add = bus.opcode == OP_ADD;
   assign is_sub = bus.opcode == OP_SUB;
   assign is_out = bus.opcode == OP_OUT;
   assign is_hlt = bus.opcode == OP_HLT;

`ifdef CONTROLLER_JUMP_EN
   assign take_jmp = (bus.opcode == OP_JMP) ||
                     ((bus.opcode == OP_JZ) && bus.zero_flag);
`else
   logic unused_ok;
   assign take_jmp  = 1'b0;
   assign unused_ok = &{1'b0, bus.zero_flag,
                        OP_JMP, OP_JZ};
`endif

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state  <= T1;
         halt_q <= 1'b0;
      end else begin
         state  <= state_n;
         halt_q <= halt_n;
      end
   end

   always_comb begin
      state_n    = state;
      halt_n     = halt_q;
      bus.halt   = halt_q;
      bus.cp     = 1'b0;
      bus.ep     = 1'b0;
      bus.low_lp = 1'b1;
      bus.low_lm = 1'b1;
      bus.low_ce = 1'b1;
      bus.low_li = 1'b1;
      bus.low_ei = 1'b1;
      bus.low_la = 1'b1;
      bus.ea     = 1'b0;
      bus.su     = 1'b0;
      bus.eu     = 1'b0;
      bus.low_lb = 1'b1;
      bus.low_lo = 1'b1;
      if (!halt_q) begin
         state_n = t_e'({state[4:0], state[5]});
         unique case (state)
            T1: begin
               bus.ep     = 1'b1;
               bus.low_lm = 1'b0;
            end
            T2: bus.cp = 1'b1;
            T3: begin
               bus.low_ce = 1'b0;
               bus.low_li = 1'b0;
            end
            T4: begin
               unique case (1'b1)
                  is_hlt: begin
                     // Freeze the ring here until reset
                     bus.halt = 1'b1;
                     halt_n   = 1'b1;
                     state_n  = T4;
                  end
                  is_lda, is_add, is_sub: begin
                     bus.low_ei = 1'b0;
                     bus.low_lm = 1'b0;
                  end
                  is_out: begin
                     bus.ea     = 1'b1;
                     bus.low_lo = 1'b0;
                  end
                  take_jmp: begin
                     bus.low_ei = 1'b0;
                     bus.low_lp = 1'b0;
                  end
                  default: ;
               endcase
            end
            T5: begin
               if (is_lda || is_add || is_sub)
                  bus.low_ce = 1'b0;
               if (is_lda)
                  bus.low_la = 1'b0;
               if (is_add || is_sub)
                  bus.low_lb = 1'b0;
            end
            T6: begin
               if (is_add || is_sub) begin
                  bus.eu     = 1'b1;
                  bus.low_la = 1'b0;
                  bus.su     = is_sub;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.t_state = state;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for controller_sequencer.
module tb_controller_sequencer;
   logic clk;
   logic sync_reset;
   int   checks;
   int   errors;

   controller_sequencer_if bus ();

   controller_sequencer dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {cp,ep,lp,lm,ce,li,ei,la,ea,su,eu,lb,lo}
   localparam logic [12:0] INACT = 13'b0011111100011;
   localparam logic [12:0] W_T1  = 13'b0110111100011;
   localparam logic [12:0] W_T2  = 13'b1011111100011;
   localparam logic [12:0] W_T3  = 13'b0011001100011;
   localparam logic [12:0] W_MEM = 13'b0010110100011;
   localparam logic [12:0] W_LDA = 13'b0011011000011;
   localparam logic [12:0] W_LDB = 13'b0011011100001;
   localparam logic [12:0] W_ADD = 13'b0011111000111;
   localparam logic [12:0] W_SUB = 13'b0011111001111;
   localparam logic [12:0] W_OUT = 13'b0011111110010;
   localparam logic [12:0] W_JMP = 13'b0001110100011;

   logic [12:0] cw;
   assign cw = {bus.cp, bus.ep, bus.low_lp,
                bus.low_lm, bus.low_ce,
                bus.low_li, bus.low_ei,
                bus.low_la, bus.ea, bus.su,
                bus.eu, bus.low_lb, bus.low_lo};

   int drivers;
   assign drivers = int'(bus.ep) + int'(!bus.low_ce)
                  + int'(!bus.low_ei) + int'(bus.ea)
                  + int'(bus.eu);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [12:0] obs,
                      input logic [12:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   task automatic chk_bus(input string tag);
      checks++;
      assert (drivers <= 1) else begin
         errors++;
         $error("FAIL %s bus drivers observed=%0d expected<=1",
                tag, drivers);
      end
   endtask

   // Starts in T1, ends in the next T1
   task automatic run_instr(input string tag,
                            input logic [3:0] op,
                            input logic zf,
                            input logic [12:0] e4,
                            input logic [12:0] e5,
                            input logic [12:0] e6);
      logic [12:0] exp_w [6];
      exp_w[0] = W_T1;
      exp_w[1] = W_T2;
      exp_w[2] = W_T3;
      exp_w[3] = e4;
      exp_w[4] = e5;
      exp_w[5] = e6;
      bus.opcode    = op;
      bus.zero_flag = zf;
      #0;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("%s T%0d state", tag, i + 1),
             {7'd0, bus.t_state}, 13'(1 << i));
         chk($sformatf("%s T%0d cw", tag, i + 1),
             cw, exp_w[i]);
         chk($sformatf("%s T%0d halt", tag, i + 1),
             {12'd0, bus.halt}, 13'd0);
         chk_bus($sformatf("%s T%0d", tag, i + 1));
         tick();
      end
   endtask

   logic [12:0] jz_exp;
   logic [3:0]  rop;
   logic [5:0]  ring;

   initial begin
      checks        = 0;
      errors        = 0;
      sync_reset    = 1'b1;
      bus.opcode    = 4'h0;
      bus.zero_flag = 1'b0;
      tick();
      tick();
      chk("reset state", {7'd0, bus.t_state}, 13'h01);
      chk("reset halt", {12'd0, bus.halt}, 13'd0);
      chk("reset cw", cw, W_T1);
      sync_reset = 1'b0;

      run_instr("LDA", 4'h0, 1'b0, W_MEM, W_LDA, INACT);
      run_instr("SUB", 4'h2, 1'b0, W_MEM, W_LDB, W_SUB);
      run_instr("ADD", 4'h1, 1'b0, W_MEM, W_LDB, W_ADD);
      run_instr("OUT", 4'h3, 1'b0, W_OUT, INACT, INACT);
      run_instr("NOP7", 4'h7, 1'b0, INACT, INACT, INACT);
      run_instr("JMP", 4'h4, 1'b1,
`ifdef CONTROLLER_JUMP_EN
                W_JMP,
`else
                INACT,
`endif
                INACT, INACT);
      run_instr("JZ0", 4'h5, 1'b0, INACT, INACT, INACT);
`ifdef CONTROLLER_JUMP_EN
      jz_exp = W_JMP;
`else
      jz_exp = INACT;
`endif
      run_instr("JZ1", 4'h5, 1'b1, jz_exp, INACT, INACT);

      // Halt
      bus.opcode = 4'hF;
      tick();
      tick();
      tick();
      chk("hlt T4 state", {7'd0, bus.t_state}, 13'h08);
      chk("hlt T4 halt", {12'd0, bus.halt}, 13'd1);
      chk("hlt T4 cw", cw, INACT);
      for (int i = 0; i < 10; i++) tick();
      bus.opcode = 4'h3;
      #1;
      chk("halted state", {7'd0, bus.t_state}, 13'h08);
      chk("halted halt", {12'd0, bus.halt}, 13'd1);
      chk("halted cw", cw, INACT);
      sync_reset = 1'b1;
      tick();
      sync_reset = 1'b0;
      chk("unhalt state", {7'd0, bus.t_state}, 13'h01);
      chk("unhalt halt", {12'd0, bus.halt}, 13'd0);

      // Reset during T5 of ADD
      bus.opcode = 4'h1;
      for (int i = 0; i < 4; i++) tick();
      chk("abort T5 state", {7'd0, bus.t_state}, 13'h10);
      chk("abort T5 cw", cw, W_LDB);
      sync_reset = 1'b1;
      tick();
      sync_reset = 1'b0;
      chk("abort state", {7'd0, bus.t_state}, 13'h01);
      chk("abort cw", cw, W_T1);
      chk("abort no la", {12'd0, bus.low_la}, 13'd1);

      // Random opcodes (halt excluded)
      ring = 6'b000001;
      for (int n = 0; n < 200; n++) begin
         rop = 4'($urandom_range(0, 14));
         bus.opcode    = rop;
         bus.zero_flag = 1'($urandom_range(0, 1));
         #0;
         for (int i = 0; i < 6; i++) begin
            chk_bus("rand");
`ifndef CONTROLLER_JUMP_EN
            chk("rand lp", {12'd0, bus.low_lp}, 13'd1);
`endif
            chk("rand ring", {7'd0, bus.t_state},
                {7'd0, ring});
            ring = {ring[4:0], ring[5]};
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=done");
      $fatal(1, "timeout");
   end
endmodule
